rlbp_code_capture: RTL
======================

Name: rlbp_code_capture

Overview:
- Downstream consumer of the comparator decision (CMP) produced by the analog SystemLevel macro.
- Synchronises CMP into the digital domain and samples it once per sequencer strobe.
- Packs NBITS successive decisions (one per photodiode pair comparison) into one LBP code word.
- Buffers completed codes in a small FIFO read by the rlbp_macro Wishbone register file, and raises an interrupt at a fill threshold.

Parameters:
- NBITS, 12, comparisons per code word (one per photodiode pair PD1..PD12).
- DEPTH, 4, FIFO depth in code words; must be a power of two, minimum 2.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous cmp input; minimum 2.
- IRQ_LEVEL, 1, FIFO occupancy at or above which irq_o asserts; range 1..DEPTH.

Ports:
- wb_clk_i  in  1  system clock; the only clock in the block.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cmp_i  in  1  comparator output from the analog macro; asynchronous.
- start_i  in  1  one-cycle pulse from the sequencer: begin a new code.
- sample_i  in  1  one-cycle strobe: capture the current synchronised cmp as the next bit.
- clr_i  in  1  synchronous flush of the FIFO, overflow flag and FSM.
- rd_en_i  in  1  pop the FIFO head; ignored when empty.
- code_o  out  NBITS  FIFO head code word (fall-through).
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- ovf_o  out  1  sticky overflow flag: a completed code was dropped.
- busy_o  out  1  FSM is in ACQ or PUSH.
- irq_o  out  1  level_o >= IRQ_LEVEL, registered.

Behaviour:
- Reset (wb_rst_ni low, asynchronous): FSM=IDLE, bit counter=0, shift register=0, synchroniser flops=0, FIFO pointers=0.
- Output values during reset: code_o=0, empty_o=1, full_o=0, level_o=0, ovf_o=0, busy_o=0, irq_o=0.
- Synchroniser: cmp_s is cmp_i delayed through SYNC_STAGES flops. cmp_i must be stable for SYNC_STAGES cycles before a sample_i strobe. A sample captures cmp_s in the strobe cycle.
- IDLE: sample_i is ignored. start_i moves to ACQ, clears the bit counter and clears the shift register.
- ACQ, on each sample_i: bit[cnt] <= cmp_s, filled LSB first (the first strobe is bit 0), then cnt <= cnt+1.
- ACQ completion: the strobe with cnt==NBITS-1 moves to PUSH on the next edge.
- ACQ restart: start_i in ACQ discards the partial code and restarts at cnt=0, shift register 0.
- ACQ collision: if start_i and sample_i arrive in the same cycle, start_i wins and the sample is dropped.
- PUSH (exactly one cycle): writes the code into the FIFO, then returns to IDLE. start_i and sample_i are ignored in PUSH.
- Latency: the code is visible on code_o and empty_o falls 2 cycles after the final sample_i strobe, provided the FIFO was empty.
- FIFO: circular, DEPTH entries. Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty on wrap-around.
- code_o always shows the head entry; it shows the last-read value when empty and is 0 after reset.
- Pop: rd_en_i with empty_o=0 advances the read pointer on the next edge. rd_en_i while empty has no effect.
- Push when full and no pop in the same cycle: the code is dropped and ovf_o sets. ovf_o stays set until clr_i or reset.
- Push and pop in the same cycle: both happen and level is unchanged. This includes the full case, where there is no overflow.
- Flags: level_o, empty_o and full_o derive from the pointers.
- irq_o: registered from level_o, so it lags the occupancy by one cycle.
- clr_i has the highest synchronous priority. It returns the FSM to IDLE, sets cnt=0, resets the pointers, clears ovf_o, and drops any push or pop in that cycle.
- clr_i does not clear FIFO storage contents or code_o.
- busy_o = 1 in ACQ and PUSH.

Test Plan:
- Reset mid-ACQ, after 5 of 12 samples: assert wb_rst_ni low asynchronously -> all outputs go to their reset values at once. A new start_i with 12 samples afterwards -> exactly one code, with no leftover bits.
- Basic code: start_i, then 12 strobes with cmp_i pattern bit0..bit11 = 1,0,1,1,0,0,0,0,1,0,0,1 -> code_o=12'h90D, level_o=1, irq_o=1 one cycle later.
- Synchroniser: toggle cmp_i 1 cycle before a strobe -> the old value is captured. Hold it for 2 cycles before the strobe -> the new value is captured.
- Overflow: fill 4 codes (12'h001..12'h004), complete a fifth (12'h005) with no reads -> full_o=1, ovf_o=1, reads return 001..004 in order, then empty_o=1.
- Full and simultaneous read: with the FIFO full, assert rd_en_i in the PUSH cycle of a fifth code -> ovf_o stays 0, level_o stays 4, and the fifth code is read last.
- Restart and clear:
  - start_i after 7 samples, then 12 samples of all 1 -> code 12'hFFF.
  - clr_i with level_o=3 and ovf_o=1 -> level_o=0, ovf_o=0, empty_o=1, busy_o=0 on the next cycle.

Source files
------------

// File: rtl/rlbp_code_capture.sv
// Samples the synchronised comparator decision on sequencer strobes, packs NBITS
// decisions LSB-first into an LBP code word and queues completed codes in a small FIFO.
//
// state  | meaning
// IDLE   | waiting for start_i; strobes ignored
// ACQ    | collecting decisions, one per sample_i
// PUSH   | one cycle: completed code written into the FIFO
module rlbp_code_capture #(
    parameter int NBITS       = 12,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IRQ_LEVEL   = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     cmp_i,
    input  logic                     start_i,
    input  logic                     sample_i,
    input  logic                     clr_i,
    input  logic                     rd_en_i,
    output logic [NBITS-1:0]         code_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    output logic                     busy_o,
    output logic                     irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NBITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cmp_s;
    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [NBITS-1:0]       shift_q;
    logic [NBITS-1:0]       mem [DEPTH];
    logic [AW:0]            wptr;
    logic [AW:0]            rptr;
    logic [NBITS-1:0]       last_q;
    logic                   push;
    logic                   do_pop;
    logic                   do_push;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_i};
        end
    end

    assign cmp_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shift_q <= '0;
        end else if (clr_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state   <= S_ACQ;
                        cnt     <= '0;
                        shift_q <= '0;
                    end
                end
                S_ACQ: begin
                    // a start in the same cycle as a strobe wins; the strobe is lost
                    if (start_i) begin
                        cnt     <= '0;
                        shift_q <= '0;
                    end else if (sample_i) begin
                        shift_q <= shift_q | (NBITS'(cmp_s) << cnt);
                        cnt     <= cnt + 1'b1;
                        if (cnt == CW'(NBITS - 1)) begin
                            state <= S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign push    = (state == S_PUSH);
    assign busy_o  = (state != S_IDLE);
    assign level_o = wptr - rptr;
    assign empty_o = (level_o == '0);
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign do_pop  = rd_en_i && !empty_o && !clr_i;
    // a full FIFO still accepts the push when the head leaves in the same cycle
    assign do_push = push && (!full_o || do_pop) && !clr_i;

    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wptr   <= '0;
            rptr   <= '0;
            ovf_o  <= 1'b0;
            last_q <= '0;
            irq_o  <= 1'b0;
        end else begin
            irq_o <= (level_o >= (AW+1)'(IRQ_LEVEL));
            if (clr_i) begin
                wptr  <= '0;
                rptr  <= '0;
                ovf_o <= 1'b0;
            end else begin
                if (do_push) begin
                    wptr <= wptr + 1'b1;
                end
                if (do_pop) begin
                    rptr   <= rptr + 1'b1;
                    last_q <= mem[rptr[AW-1:0]];
                end
                if (push && full_o && !do_pop) begin
                    ovf_o <= 1'b1;
                end
            end
        end
    end

    // when empty, hold the most recently read word rather than a stale slot
    assign code_o = empty_o ? last_q : mem[rptr[AW-1:0]];

endmodule
